// File: rtl/display_lcd_driver.sv
// display_lcd_driver
// Streams a 32-character display buffer to a 16x2 HD44780-compatible LCD
// over its 8-bit parallel bus. After the power-on delay and the init command
// sequence, the buffer is snapshotted and both lines are refreshed
// continuously, one frame per snapshot.
// Optional build macro LCD_CHANGE_ONLY_EN: only send a frame when the buffer
// differs from the last transmitted snapshot (the first frame is always sent).
module display_lcd_driver #(
    parameter int DisplayBufferSize = 256,
    parameter int PowerOnCycles     = 1000000,
    parameter int EnablePulseCycles = 25,
    parameter int CmdWaitCycles     = 2500,
    parameter int ClearWaitCycles   = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DisplayBufferSize-1:0] DisplayBuffer,
    output logic                         LCD_RS,
    output logic                         LCD_RW,
    output logic                         LCD_E,
    output logic [7:0]                   LCD_DATA,
    output logic                         InitDone,
    output logic                         FrameDone
);

    // Terminal counts: each phase counter runs 0 .. N-1.
    localparam logic [31:0] POWER_LAST = 32'(PowerOnCycles - 1);
    localparam logic [31:0] PULSE_LAST = 32'(EnablePulseCycles - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CmdWaitCycles - 1);
    localparam logic [31:0] CLEAR_LAST = 32'(ClearWaitCycles - 1);

    typedef enum logic [1:0] {POWER_WAIT, INIT, SNAPSHOT, FRAME} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

    state_t                       r_state;
    phase_t                       r_phase;
    logic [31:0]                  r_cnt;
    logic [5:0]                   r_idx;
    logic [DisplayBufferSize-1:0] r_snap;
    logic [31:0]                  w_hold_last;
    logic                         w_take;

    // Init command list, issued in index order.
    function automatic logic [7:0] f_init_cmd(input logic [5:0] idx);
        case (idx)
            6'd0, 6'd1, 6'd2: return 8'h38;
            6'd3:             return 8'h0C;
            6'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    // Character k sits in the k-th byte counted from the top of the buffer.
    function automatic logic [7:0] f_char(input logic [DisplayBufferSize-1:0] snap,
                                          input logic [4:0] k);
        logic [DisplayBufferSize-1:0] w;
        w = snap << {k, 3'b000};
        return w[DisplayBufferSize-1 -: 8];
    endfunction

    // Frame transfer order: 0x80, chars 0..15, 0xC0, chars 16..31.
    function automatic logic [7:0] f_frame_byte(input logic [DisplayBufferSize-1:0] snap,
                                                input logic [5:0] idx);
        logic [5:0] k;
        if (idx == 6'd0)       return 8'h80;
        else if (idx == 6'd17) return 8'hC0;
        else if (idx <= 6'd16) k = idx - 6'd1;
        else                   k = idx - 6'd2;
        return f_char(snap, k[4:0]);
    endfunction

    function automatic logic f_frame_rs(input logic [5:0] idx);
        return !(idx == 6'd0 || idx == 6'd17);
    endfunction

    // Clear-display needs the long wait; every other transfer uses the short one.
    assign w_hold_last = (!LCD_RS && LCD_DATA == 8'h01) ? CLEAR_LAST : CMD_LAST;
    assign LCD_RW      = 1'b0;

`ifdef LCD_CHANGE_ONLY_EN
    logic r_sent;

    assign w_take = !r_sent || (DisplayBuffer != r_snap);

    // Remember that at least one frame has been started since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sent <= 1'b0;
        end else if (r_state == SNAPSHOT && w_take) begin
            r_sent <= 1'b1;
        end
    end
`else
    assign w_take = 1'b1;
`endif

    // Main sequencer: power wait, init commands, snapshot/frame refresh loop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= POWER_WAIT;
            r_phase   <= SETUP;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_snap    <= '0;
            LCD_RS    <= 1'b0;
            LCD_E     <= 1'b0;
            LCD_DATA  <= 8'h00;
            InitDone  <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            case (r_state)
                POWER_WAIT: begin
                    if (r_cnt == POWER_LAST) begin
                        r_state  <= INIT;
                        r_phase  <= SETUP;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= f_init_cmd(6'd0);
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                SNAPSHOT: begin
                    if (w_take) begin
                        r_snap   <= DisplayBuffer;
                        r_state  <= FRAME;
                        r_phase  <= SETUP;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= 8'h80;
                    end
                end
                default: begin
                    case (r_phase)
                        SETUP: begin
                            LCD_E   <= 1'b1;
                            r_phase <= PULSE;
                            r_cnt   <= '0;
                        end
                        PULSE: begin
                            if (r_cnt == PULSE_LAST) begin
                                LCD_E   <= 1'b0;
                                r_phase <= HOLD;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                        default: begin
                            if (r_cnt == w_hold_last) begin
                                r_cnt <= '0;
                                if (r_state == INIT) begin
                                    if (r_idx == 6'd5) begin
                                        InitDone <= 1'b1;
                                        r_state  <= SNAPSHOT;
                                    end else begin
                                        r_idx    <= r_idx + 6'd1;
                                        r_phase  <= SETUP;
                                        LCD_RS   <= 1'b0;
                                        LCD_DATA <= f_init_cmd(r_idx + 6'd1);
                                    end
                                end else begin
                                    if (r_idx == 6'd33) begin
                                        FrameDone <= 1'b1;
                                        r_state   <= SNAPSHOT;
                                    end else begin
                                        r_idx    <= r_idx + 6'd1;
                                        r_phase  <= SETUP;
                                        LCD_RS   <= f_frame_rs(r_idx + 6'd1);
                                        LCD_DATA <= f_frame_byte(r_snap, r_idx + 6'd1);
                                    end
                                end
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_lcd_driver.sv
// Testbench for display_lcd_driver: a cycle-timeline model of the LCD bus
// plus literal checks on transfer order, latency and frame period.
module tb_display_lcd_driver;

    localparam int PON       = 100;
    localparam int PUL       = 2;
    localparam int CW        = 10;
    localparam int CLW       = 40;
    localparam int XFER      = 1 + PUL + CW;            // 13
    localparam int INIT_LEN  = PON + 5 * XFER + 1 + PUL + CLW; // 208
    localparam int FRAME_LEN = 34 * XFER;               // 442

    logic         clk;
    logic         reset;
    logic [255:0] DisplayBuffer;
    logic         LCD_RS, LCD_RW, LCD_E, InitDone, FrameDone;
    logic [7:0]   LCD_DATA;

    display_lcd_driver #(
        .DisplayBufferSize(256),
        .PowerOnCycles(PON),
        .EnablePulseCycles(PUL),
        .CmdWaitCycles(CW),
        .ClearWaitCycles(CLW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .DisplayBuffer(DisplayBuffer),
        .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW),
        .LCD_E(LCD_E),
        .LCD_DATA(LCD_DATA),
        .InitDone(InitDone),
        .FrameDone(FrameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] init_cmd [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    bit         started = 0;
    int         m_n;        // cycles since the last reset edge
    int         m_fs;       // cycle index of the current SNAPSHOT
    bit         m_sent;
    bit         m_fd;
    logic [7:0] m_chr [32];
`ifdef LCD_CHANGE_ONLY_EN
    logic [255:0] m_last;
`endif

    always @(posedge clk) begin
        bit take;
        started = 1;
        if (reset) begin
            m_n    = 0;
            m_fs   = INIT_LEN;
            m_sent = 0;
            m_fd   = 0;
        end else begin
            m_fd = 0;
            if (m_n >= INIT_LEN && m_n == m_fs) begin
                take = 1;
`ifdef LCD_CHANGE_ONLY_EN
                take = !m_sent || (DisplayBuffer != m_last);
                if (take) m_last = DisplayBuffer;
`endif
                if (take) begin
                    for (int k = 0; k < 32; k++) m_chr[k] = DisplayBuffer[255-8*k -: 8];
                    m_sent = 1;
                end else begin
                    m_fs = m_fs + 1;
                end
            end else if (m_n >= INIT_LEN && m_n == m_fs + FRAME_LEN) begin
                m_fs = m_n + 1;
                m_fd = 1;
            end
            m_n = m_n + 1;
        end
    end

    // Expected {RS, RW, E, DATA, InitDone, FrameDone} for the current cycle.
    function automatic logic [12:0] f_expect();
        logic       rs, e, idone;
        logic [7:0] d;
        int s, len, o, i, p;
        rs = 0; e = 0; idone = 0; d = 8'h00;
        if (m_n < PON) begin
            d = 8'h00;
        end else if (m_n < INIT_LEN) begin
            s = PON;
            for (int j = 0; j < 6; j++) begin
                len = 1 + PUL + ((init_cmd[j] == 8'h01) ? CLW : CW);
                if (m_n >= s && m_n < s + len) begin
                    d = init_cmd[j];
                    e = (m_n - s >= 1) && (m_n - s <= PUL);
                end
                s = s + len;
            end
        end else if (m_n == m_fs) begin
            idone = 1;
            if (m_sent) begin rs = 1; d = m_chr[31]; end
            else d = 8'h06;
        end else begin
            idone = 1;
            o = m_n - m_fs - 1;
            i = o / XFER;
            p = o % XFER;
            e = (p >= 1) && (p <= PUL);
            if (i == 0)       d = 8'h80;
            else if (i <= 16) begin rs = 1; d = m_chr[i-1]; end
            else if (i == 17) d = 8'hC0;
            else              begin rs = 1; d = m_chr[i-2]; end
        end
        return {rs, 1'b0, e, d, idone, m_fd};
    endfunction

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [12:0] exp_v, act_v;
        if (started) begin
            exp_v = f_expect();
            act_v = {LCD_RS, LCD_RW, LCD_E, LCD_DATA, InitDone, FrameDone};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL bus n=%0d {rs,rw,e,data,init,fd} actual=%b required=%b",
                             m_n, act_v, exp_v);
            end
        end
    end

    // Bus monitor: log every LCD_E rise, InitDone rise and FrameDone cycle
    typedef struct { int n; logic rs; logic [7:0] d; } ev_t;
    ev_t  ev_q [$];
    int   fd_q [$];
    int   id_rise = -1;
    logic prev_e = 1'b0;
    logic prev_id = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            if (LCD_E === 1'b1 && prev_e !== 1'b1) ev_q.push_back('{m_n, LCD_RS, LCD_DATA});
            if (InitDone === 1'b1 && prev_id !== 1'b1) id_rise = m_n;
            if (FrameDone === 1'b1) fd_q.push_back(m_n);
            prev_e  = LCD_E;
            prev_id = InitDone;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_ev(input string name, input int idx, input logic rs, input logic [7:0] d);
        n_cmp++;
        if (idx >= ev_q.size()) begin
            n_bad++;
            $display("FAIL %s transfer %0d missing (only %0d)", name, idx, ev_q.size());
        end else if (ev_q[idx].rs !== rs || ev_q[idx].d !== d) begin
            n_bad++;
            $display("FAIL %s actual rs=%b data=%h required rs=%b data=%h",
                     name, ev_q[idx].rs, ev_q[idx].d, rs, d);
        end
    endtask

    task automatic wait_ev(input int cnt, input int budget);
        int k;
        k = 0;
        while (ev_q.size() < cnt && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (ev_q.size() < cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout waiting for %0d transfers actual=%0d", cnt, ev_q.size());
        end
    endtask

    task automatic ev_n(input string name, input int idx, input int req);
        if (idx < ev_q.size()) check(name, ev_q[idx].n, req);
        else check(name, -1, req);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        DisplayBuffer = "HELLO WORLD     RISC CPU        ";
        repeat (3) @(negedge clk);
        check("reset_state", {LCD_RS, LCD_RW, LCD_E, LCD_DATA, InitDone, FrameDone}, 0);
        reset = 1'b0;

        // Init sequence and first frame
        wait_ev(40, 2000);
        ev_n("first_e_rise", 0, 101);
        for (int j = 0; j < 6; j++) check_ev("init_cmd", j, 1'b0, init_cmd[j]);
        if (ev_q.size() >= 6) begin
            check("cmd_xfer_len", ev_q[4].n - ev_q[3].n, 13);
            check("clear_xfer_len", ev_q[5].n - ev_q[4].n, 43);
        end
        check("initdone_cycle", id_rise, 208);
        ev_n("frame1_first_rise", 6, 210);
        check_ev("frame1_line1_cmd", 6, 1'b0, 8'h80);
        check_ev("frame1_char0", 7, 1'b1, "H");
        check_ev("frame1_char10", 17, 1'b1, "D");
        check_ev("frame1_line2_cmd", 23, 1'b0, 8'hC0);
        check_ev("frame1_char16", 24, 1'b1, "R");
        check_ev("frame1_char31", 39, 1'b1, " ");

`ifndef LCD_CHANGE_ONLY_EN
        // Mid-line-1 change of character 0 must not tear the running frame
        wait_ev(48, 1000);
        DisplayBuffer[255 -: 8] = "J";
        wait_ev(76, 1500);
        check_ev("frame2_char0_old", 41, 1'b1, "H");
        check_ev("frame3_char0_new", 75, 1'b1, "J");
        if (fd_q.size() >= 2) begin
            check("first_framedone", fd_q[0], 651);
            check("frame_period", fd_q[1] - fd_q[0], 443);
        end else begin
            check("framedone_count", fd_q.size(), 2);
        end
`else
        k = 0;
        while (fd_q.size() < 1 && k < 1000) begin @(negedge clk); k++; end
        check("first_framedone", fd_q.size(), 1);
        k = ev_q.size();
        repeat (2000) @(negedge clk);
        check("idle_when_unchanged", ev_q.size(), k);
        DisplayBuffer[7:0] = DisplayBuffer[7:0] ^ 8'h5A;
        repeat (3) @(negedge clk);
        check("restart_on_change", ev_q.size(), k + 1);
`endif

        // Randomised buffer updates at random times, including zero bytes
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(20, 700)) @(negedge clk);
            for (int c = 0; c < 32; c++)
                DisplayBuffer[255-8*c -: 8] = ($urandom_range(0, 3) == 0) ? 8'h00
                                              : 8'($urandom_range(32, 126));
        end
        repeat (900) @(negedge clk);

        // One-cycle reset while the enable strobe is high
        k = 0;
        while (LCD_E !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
        check("e_high_before_reset", LCD_E, 1);
        reset = 1'b1;
        @(negedge clk);
        check("e_low_after_reset", LCD_E, 0);
        check("initdone_cleared", InitDone, 0);
        reset = 1'b0;
        ev_q.delete();
        id_rise = -1;
        wait_ev(6, 400);
        ev_n("reinit_first_rise", 0, 101);
        repeat (300) @(negedge clk);
        check("reinit_initdone", id_rise, 208);
        repeat (200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_lcd_driver.md
# display_lcd_driver

Streams the memory-mapped display buffer to a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus. It sits directly downstream of the memory block and consumes its `DisplayBuffer` output: 32 bytes, character 0 in the top byte. It runs the LCD power-on initialisation sequence, then refreshes both lines continuously. Each frame is taken from a snapshot so that CPU stores made during a refresh never tear a frame.

## Interface
Parameters:
- `DisplayBufferSize`, 256: buffer width in bits; fixed at 256 (2 lines x 16 chars x 8 bits).
- `PowerOnCycles`, 1000000: idle cycles after reset before the first command (20 ms at 50 MHz).
- `EnablePulseCycles`, 25: cycles `LCD_E` is held high per transfer.
- `CmdWaitCycles`, 2500: post-transfer wait for every transfer except clear.
- `ClearWaitCycles`, 100000: post-transfer wait after command 0x01.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `DisplayBuffer` input 256: character k (0..31) = `DisplayBuffer[255-8k -: 8]`. k 0..15 is line 1, k 16..31 is line 2.
- `LCD_RS` output 1: 0 = command, 1 = character data.
- `LCD_RW` output 1: tied 0 (write only, busy flag never read).
- `LCD_E` output 1: enable strobe.
- `LCD_DATA` output 8: bus byte.
- `InitDone` output 1: high once the init sequence completes; stays high until reset.
- `FrameDone` output 1: one-cycle pulse at the end of the wait of the last character of each frame.

## Operation
- FSM states: `POWER_WAIT` -> `INIT` -> `SNAPSHOT` -> `FRAME` -> `SNAPSHOT` ...
- A transfer engine with sub-phases `SETUP`, `PULSE`, `HOLD` executes one byte per transfer.
- `POWER_WAIT` counts `PowerOnCycles` with all outputs at their reset values.
- `INIT` issues, in order, the commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. After the 0x06 wait completes, `InitDone` is set.
- `SNAPSHOT` copies `DisplayBuffer` into an internal 256-bit register in one cycle.
- `FRAME` issues 34 transfers, all taken from the snapshot:
  - command 0x80;
  - chars 0..15 with RS=1;
  - command 0xC0;
  - chars 16..31 with RS=1.
- After the last wait of `FRAME`: `FrameDone` pulses and the FSM returns to `SNAPSHOT`.
- Buffer changes during `FRAME` are invisible until the next `SNAPSHOT`.
- Character bytes are sent unmodified, including 0x00.
- Counters are wide enough for the largest parameter. A counter restarts from 0 at each phase entry and never wraps inside a phase.

## Timing
- Reset values: `LCD_RS`=0, `LCD_RW`=0, `LCD_E`=0, `LCD_DATA`=0x00, `InitDone`=0, `FrameDone`=0. The snapshot register and all counters are cleared.
- Transfer phases:
  - `SETUP`: exactly 1 cycle. `LCD_RS`/`LCD_DATA` become valid and `LCD_E`=0.
  - `PULSE`: `LCD_E`=1 for exactly `EnablePulseCycles` cycles.
  - `HOLD`: `LCD_E`=0 for W cycles. W = `ClearWaitCycles` for 0x01, otherwise `CmdWaitCycles`.
- Transfer length is 1+`EnablePulseCycles`+W cycles. The next transfer's `SETUP` follows immediately.
- `LCD_RS` and `LCD_DATA` are stable from `SETUP` through the end of `HOLD`. They change only on a `SETUP` cycle.
- The first `SETUP` occurs exactly `PowerOnCycles` cycles after `reset` deasserts.
- `SNAPSHOT` costs 1 cycle; all outputs hold during it.
- `reset` asserted in any state or phase: on the next edge `LCD_E`=0 and every output takes its reset value. The FSM restarts at `POWER_WAIT`. A truncated `LCD_E` pulse is acceptable.
- `reset` asserted together with any other event takes priority.

## Configuration
- `LCD_CHANGE_ONLY_EN` defined:
  - `SNAPSHOT` compares `DisplayBuffer` with the last transmitted snapshot.
  - If they are equal, the FSM stays in `SNAPSHOT`, re-comparing every cycle, and no transfers occur.
  - If they differ, it latches the buffer and runs `FRAME`.
  - The first frame after init is always sent.
- `LCD_CHANGE_ONLY_EN` undefined: frames repeat back-to-back unconditionally.

## Test plan
Test parameters: `PowerOnCycles`=100, `EnablePulseCycles`=2, `CmdWaitCycles`=10, `ClearWaitCycles`=40.
- Reset release, bus monitor -> first `LCD_E` rise at cycle 101. Six commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0. The 0x01 transfer lasts 43 cycles, the others 13. `InitDone` rises after the 0x06 wait.
- Buffer = ASCII "HELLO WORLD     " + "RISC CPU        " -> one frame: 0x80, 'H'..' ' (RS=1), 0xC0, 'R'..' '. Frame is 442 cycles; `FrameDone` is a single-cycle pulse.
- Change `DisplayBuffer` top byte to 'J' midway through line 1 -> current frame still sends 'H'; the next frame sends 'J'.
- Assert `reset` for 1 cycle while `LCD_E`=1 -> `LCD_E`=0 on the next edge. `InitDone`=0. Full init repeats starting 100 cycles later.
- With `LCD_CHANGE_ONLY_EN`, buffer held constant -> after the first frame, no `LCD_E` activity for 2000 cycles. Change one byte -> a new frame starts within 2 cycles.
- Without the macro, buffer held constant -> `FrameDone` pulses every 443 cycles (442 transfer cycles + 1 `SNAPSHOT` cycle).
